// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI-lite register bank: response code, register indices
// and read-channel FSM encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_R1     = 2'd1;
  localparam logic [1:0] IDX_R2     = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/axi_lite_read_ch.sv
// AR/R handshake FSM: ARREADY one cycle after ARVALID, RVALID one cycle after the
// address handshake; RDATA held until RREADY, one read outstanding at a time.
module axi_lite_read_ch
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [1:0]        ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [1:0]        rd_idx,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_word
);

  rd_state_e         state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  assign rd_idx = ARADDR;
  assign rd_en  = (state_q == RD_ADDR) && ARVALID && arready_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (ARVALID) begin
            arready_q <= 1'b1;
            state_q   <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          // rd_word is sampled at this edge, so a same-cycle write is not seen
          if (rd_en) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            state_q   <= RD_DATA;
          end else if (!ARVALID) begin
            arready_q <= 1'b0;
            state_q   <= RD_IDLE;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= RD_IDLE;
          end
        end
        default: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          state_q   <= RD_IDLE;
        end
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = RESP_OKAY;

endmodule

// File: rtl/axi_lite_regbank.sv
// Four-entry register bank fed by the write-channel strobe; writes land one cycle later,
// no write backpressure; reads via the AXI-lite AR/R channel held until RREADY.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RST_REG0 = '0,
  parameter logic [DATA_W-1:0] RST_REG1 = '0,
  parameter logic [DATA_W-1:0] RST_REG2 = '0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_addr,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] status_in,
  input  logic [1:0]        ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              start_pulse,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic [3:0]        wr_hit
);

  localparam logic [DATA_W-1:0] RST_CTRL = {RST_REG0[DATA_W-1:1], 1'b0};

  logic [DATA_W-1:0] reg0_q, reg0_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic              start_q, start_d;
  logic [3:0]        hit_q, hit_d;

  logic [1:0]        rd_idx;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    reg0_d  = reg0_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    start_d = 1'b0;
    hit_d   = 4'b0000;
    if (wr_valid) begin
      hit_d = idx_onehot(wr_addr);
      case (wr_addr)
        // bit 0 of control is a trigger, never stored
        IDX_CTRL: begin
          reg0_d  = {wr_data[DATA_W-1:1], 1'b0};
          start_d = wr_data[0];
        end
        IDX_R1:  reg1_d = wr_data;
        IDX_R2:  reg2_d = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      reg0_q  <= RST_CTRL;
      reg1_q  <= RST_REG1;
      reg2_q  <= RST_REG2;
      start_q <= 1'b0;
      hit_q   <= 4'b0000;
    end else begin
      reg0_q  <= reg0_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      start_q <= start_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_en) begin
      case (rd_idx)
        IDX_CTRL: rd_word = reg0_q;
        IDX_R1:   rd_word = reg1_q;
        IDX_R2:   rd_word = reg2_q;
        default:  rd_word = status_in;
      endcase
    end
  end

  axi_lite_read_ch #(
    .DATA_W (DATA_W)
  ) u_read_ch (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .rd_idx  (rd_idx),
    .rd_en   (rd_en),
    .rd_word (rd_word)
  );

  assign ctrl_out    = reg0_q;
  assign reg1_out    = reg1_q;
  assign reg2_out    = reg2_q;
  assign start_pulse = start_q;
  assign wr_hit      = hit_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank; inputs driven and outputs sampled 1 time unit
// after each rising edge.
module tb_axi_lite_regbank;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] wr_data;
  logic [1:0]  wr_addr;
  logic        wr_valid;
  logic [31:0] status_in;
  logic [1:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] ctrl_out;
  logic        start_pulse;
  logic [31:0] reg1_out;
  logic [31:0] reg2_out;
  logic [3:0]  wr_hit;

  int n_cmp;
  int n_err;

  axi_lite_regbank #(
    .DATA_W   (32),
    .RST_REG0 (32'h0000_0000),
    .RST_REG1 (32'hA5A5_0001),
    .RST_REG2 (32'h0000_0000)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_valid    (wr_valid),
    .status_in   (status_in),
    .ARADDR      (ARADDR),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .ctrl_out    (ctrl_out),
    .start_pulse (start_pulse),
    .reg1_out    (reg1_out),
    .reg2_out    (reg2_out),
    .wr_hit      (wr_hit)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  // Full read with RREADY asserted once RVALID is seen
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ARADDR  = a;
    ARVALID = 1'b1;
    step();
    chk({tag, "_arready"}, 32'(ARREADY), 32'h1);
    chk({tag, "_rvalid_early"}, 32'(RVALID), 32'h0);
    step();
    ARVALID = 1'b0;
    chk({tag, "_rvalid"}, 32'(RVALID), 32'h1);
    chk({tag, "_rdata"}, RDATA, exp);
    chk({tag, "_rresp"}, 32'(RRESP), 32'h0);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk({tag, "_rvalid_done"}, 32'(RVALID), 32'h0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    ARESETn   = 1'b0;
    wr_data   = '0;
    wr_addr   = '0;
    wr_valid  = 1'b0;
    status_in = '0;
    ARADDR    = '0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    step();
    step();
    ARESETn = 1'b1;

    // 1: reset state and read of overridden reset value
    chk("rst_arready", 32'(ARREADY), 32'h0);
    chk("rst_rvalid", 32'(RVALID), 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_start", 32'(start_pulse), 32'h0);
    chk("rst_hit", 32'(wr_hit), 32'h0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_reg1", reg1_out, 32'hA5A5_0001);
    chk("rst_reg2", reg2_out, 32'h0);
    rd("t1", 2'd1, 32'hA5A5_0001);

    // 2: write reg2
    wr(2'd2, 32'hDEAD_BEEF);
    chk("t2_reg2", reg2_out, 32'hDEAD_BEEF);
    chk("t2_hit", 32'(wr_hit), 32'h4);
    step();
    chk("t2_hit_clr", 32'(wr_hit), 32'h0);
    rd("t2", 2'd2, 32'hDEAD_BEEF);

    // 3: start bit self-clears, back-to-back pulses
    wr(2'd0, 32'h0000_0013);
    chk("t3_ctrl", ctrl_out, 32'h0000_0012);
    chk("t3_start", 32'(start_pulse), 32'h1);
    chk("t3_hit", 32'(wr_hit), 32'h1);
    step();
    chk("t3_start_clr", 32'(start_pulse), 32'h0);
    wr_addr  = 2'd0;
    wr_data  = 32'h0000_0001;
    wr_valid = 1'b1;
    step();
    chk("t3_pulse_a", 32'(start_pulse), 32'h1);
    step();
    wr_valid = 1'b0;
    chk("t3_pulse_b", 32'(start_pulse), 32'h1);
    chk("t3_ctrl_b", ctrl_out, 32'h0);
    step();
    chk("t3_pulse_end", 32'(start_pulse), 32'h0);

    // 4: index 3 is read-only
    status_in = 32'h1234_5678;
    wr(2'd3, 32'hFFFF_FFFF);
    chk("t4_hit", 32'(wr_hit), 32'h8);
    rd("t4", 2'd3, 32'h1234_5678);

    // 5: backpressure on R while status changes
    ARADDR  = 2'd3;
    ARVALID = 1'b1;
    step();
    step();
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      status_in = ~status_in;
      step();
      chk("t5_rvalid_hold", 32'(RVALID), 32'h1);
      chk("t5_rdata_hold", RDATA, 32'h1234_5678);
      chk("t5_arready_low", 32'(ARREADY), 32'h0);
    end
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk("t5_rvalid_done", 32'(RVALID), 32'h0);
    step();
    chk("t5_no_arready", 32'(ARREADY), 32'h0);

    // ARVALID withdrawn while in ADDR
    ARADDR  = 2'd1;
    ARVALID = 1'b1;
    step();
    chk("drop_arready", 32'(ARREADY), 32'h1);
    ARVALID = 1'b0;
    step();
    chk("drop_arready_clr", 32'(ARREADY), 32'h0);
    chk("drop_no_rvalid", 32'(RVALID), 32'h0);

    // RREADY high before RVALID: handshake on first RVALID cycle
    RREADY  = 1'b1;
    ARADDR  = 2'd2;
    ARVALID = 1'b1;
    step();
    step();
    ARVALID = 1'b0;
    chk("rr_rvalid", 32'(RVALID), 32'h1);
    chk("rr_rdata", RDATA, 32'hDEAD_BEEF);
    step();
    chk("rr_rvalid_done", 32'(RVALID), 32'h0);
    RREADY = 1'b0;

    // 6: same-cycle write and read handshake returns old value
    wr(2'd1, 32'h0000_0001);
    ARADDR  = 2'd1;
    ARVALID = 1'b1;
    step();
    wr_addr  = 2'd1;
    wr_data  = 32'h0000_0002;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    ARVALID  = 1'b0;
    chk("t6_rdata_old", RDATA, 32'h0000_0001);
    chk("t6_reg1_new", reg1_out, 32'h0000_0002);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    rd("t6_next", 2'd1, 32'h0000_0002);

    // reset while in DATA
    wr(2'd0, 32'h0000_0040);
    wr(2'd2, 32'h0000_0055);
    ARADDR  = 2'd2;
    ARVALID = 1'b1;
    step();
    step();
    ARVALID = 1'b0;
    chk("t6r_in_data", 32'(RVALID), 32'h1);
    ARESETn = 1'b0;
    step();
    chk("t6r_rvalid", 32'(RVALID), 32'h0);
    chk("t6r_arready", 32'(ARREADY), 32'h0);
    chk("t6r_rdata", RDATA, 32'h0);
    chk("t6r_ctrl", ctrl_out, 32'h0);
    chk("t6r_reg1", reg1_out, 32'hA5A5_0001);
    chk("t6r_reg2", reg2_out, 32'h0);
    ARESETn = 1'b1;
    step();
    chk("t6r_idle", 32'(ARREADY), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
